// File: rtl/axil_pkg.sv
// Shared AXI4-Lite slave definitions: response codes, the write/read handshake
// FSM state types, and the byte-strobe merge helper.
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } axil_wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } axil_rd_state_e;

  // Replace each byte of old_w whose strobe bit is set with the matching byte of new_w.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_shadow_regfile.sv
// AXI4-Lite register file with staging/active shadowing.
// Host writes land in staging registers. Active registers (regs_out) follow
// staging either on every write (COMMIT_MODE=0) or only at frame_start
// (COMMIT_MODE=1), so fabric consumers never see a mid-frame change.
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   s_axi_lite_aw*/w*/b*   AXI4-Lite write channels (byte strobes, OKAY/SLVERR)
//   s_axi_lite_ar*/r*      AXI4-Lite read channels (1-cycle read latency)
//   frame_start            start-of-frame pulse, commit point in mode 1
//   status_in              live read-only status words, word i at [32*i+:32]
//   regs_out               active registers, reg i at [32*i+:32]
//   pending                staging written but not yet committed
//   commit_pulse           high the cycle the active registers show new contents
module axil_shadow_regfile
  import axil_pkg::*;
#(
  parameter int unsigned                 REG_COUNT    = 8,
  parameter int unsigned                 STATUS_COUNT = 2,
  parameter int unsigned                 ADDR_WIDTH   = 8,
  parameter int unsigned                 COMMIT_MODE  = 1,
  parameter logic [REG_COUNT*32-1:0]     RESET_VALUE  = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_WIDTH-1:0]        s_axi_lite_awaddr,
  input  logic                         s_axi_lite_awvalid,
  output logic                         s_axi_lite_awready,
  input  logic [31:0]                  s_axi_lite_wdata,
  input  logic [3:0]                   s_axi_lite_wstrb,
  input  logic                         s_axi_lite_wvalid,
  output logic                         s_axi_lite_wready,
  output logic [1:0]                   s_axi_lite_bresp,
  output logic                         s_axi_lite_bvalid,
  input  logic                         s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_lite_araddr,
  input  logic                         s_axi_lite_arvalid,
  output logic                         s_axi_lite_arready,
  output logic [31:0]                  s_axi_lite_rdata,
  output logic [1:0]                   s_axi_lite_rresp,
  output logic                         s_axi_lite_rvalid,
  input  logic                         s_axi_lite_rready,
  input  logic                         frame_start,
  input  logic [32*STATUS_COUNT-1:0]   status_in,
  output logic [32*REG_COUNT-1:0]      regs_out,
  output logic                         pending,
  output logic                         commit_pulse
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  axil_wr_state_e w_state, w_next;
  axil_rd_state_e r_state, r_next;

  logic [31:0] staging [REG_COUNT];
  logic [31:0] active  [REG_COUNT];

  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic [1:0]       bresp_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  logic [IDX_W-1:0] aw_idx_in, ar_idx_in, wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             do_write, wr_hit, commit_now;
  logic [31:0]      rd_data_nxt;
  logic [1:0]       rd_resp_nxt;

  // Address bits [1:0] carry no information for word-wide registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  assign aw_idx_in = s_axi_lite_awaddr[ADDR_WIDTH-1:2];
  assign ar_idx_in = s_axi_lite_araddr[ADDR_WIDTH-1:2];

  // Write address/data come from the latch when that half arrived earlier.
  assign wr_idx  = (w_state == W_HAVE_ADDR) ? aw_idx_q : aw_idx_in;
  assign wr_data = (w_state == W_HAVE_DATA) ? w_data_q : s_axi_lite_wdata;
  assign wr_strb = (w_state == W_HAVE_DATA) ? w_strb_q : s_axi_lite_wstrb;
  assign wr_hit  = 32'(wr_idx) < REG_COUNT;

  // Mode 1 commit uses the pre-write staging contents, so a write landing on
  // the frame_start edge stays pending for the following frame.
  assign commit_now = (COMMIT_MODE != 0) && frame_start && pending;

  always_comb begin
    w_next             = w_state;
    s_axi_lite_awready = 1'b0;
    s_axi_lite_wready  = 1'b0;
    do_write           = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_lite_awready = 1'b1;
        s_axi_lite_wready  = 1'b1;
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end else if (s_axi_lite_awvalid) begin
          w_next = W_HAVE_ADDR;
        end else if (s_axi_lite_wvalid) begin
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        s_axi_lite_wready = 1'b1;
        if (s_axi_lite_wvalid) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        s_axi_lite_awready = 1'b1;
        if (s_axi_lite_awvalid) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_lite_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next             = r_state;
    s_axi_lite_arready = (r_state == R_IDLE);
    case (r_state)
      R_IDLE:  if (s_axi_lite_arvalid) r_next = R_VALID;
      R_VALID: if (s_axi_lite_rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = AXI_RESP_SLVERR;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (32'(ar_idx_in) == i) begin
        rd_data_nxt = staging[i];
        rd_resp_nxt = AXI_RESP_OKAY;
      end
    end
    for (int unsigned i = 0; i < STATUS_COUNT; i++) begin
      if (32'(ar_idx_in) == REG_COUNT + i) begin
        rd_data_nxt = status_in[32*i +: 32];
        rd_resp_nxt = AXI_RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state      <= W_IDLE;
      r_state      <= R_IDLE;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bresp_q      <= AXI_RESP_OKAY;
      rdata_q      <= '0;
      rresp_q      <= AXI_RESP_OKAY;
      pending      <= 1'b0;
      commit_pulse <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        staging[i] <= RESET_VALUE[32*i +: 32];
        active[i]  <= RESET_VALUE[32*i +: 32];
      end
    end else begin
      w_state <= w_next;
      r_state <= r_next;

      if (s_axi_lite_awvalid && s_axi_lite_awready) aw_idx_q <= aw_idx_in;
      if (s_axi_lite_wvalid && s_axi_lite_wready) begin
        w_data_q <= s_axi_lite_wdata;
        w_strb_q <= s_axi_lite_wstrb;
      end

      if (do_write) bresp_q <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;

      if (s_axi_lite_arvalid && s_axi_lite_arready) begin
        rdata_q <= rd_data_nxt;
        rresp_q <= rd_resp_nxt;
      end

      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (do_write && 32'(wr_idx) == i)
          staging[i] <= strb_merge(staging[i], wr_data, wr_strb);
        if (COMMIT_MODE == 0) begin
          if (do_write && 32'(wr_idx) == i)
            active[i] <= strb_merge(staging[i], wr_data, wr_strb);
        end else if (commit_now) begin
          active[i] <= staging[i];
        end
      end

      if (COMMIT_MODE != 0) begin
        if (do_write && wr_hit && (wr_strb != 4'b0000)) pending <= 1'b1;
        else if (commit_now)                              pending <= 1'b0;
        commit_pulse <= commit_now;
      end else begin
        commit_pulse <= do_write && wr_hit;
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) regs_out[32*i +: 32] = active[i];
  end

  assign s_axi_lite_bvalid = (w_state == W_RESP);
  assign s_axi_lite_bresp  = bresp_q;
  assign s_axi_lite_rvalid = (r_state == R_VALID);
  assign s_axi_lite_rdata  = rdata_q;
  assign s_axi_lite_rresp  = rresp_q;

endmodule

// File: tb/tb_axil_shadow_regfile.sv
// Testbench for axil_shadow_regfile (COMMIT_MODE=1). Directed stimulus tasks
// push expected B/R responses into queues; a negedge monitor pops and compares
// them whenever the DUT completes a response handshake.
module tb_axil_shadow_regfile;

  localparam logic [255:0] RV = {32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h55667788, 32'h0, 32'h11223344, 32'h0};

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [7:0]   awaddr = '0;
  logic         awvalid = 1'b0, awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready = 1'b1;
  logic [7:0]   araddr = '0;
  logic         arvalid = 1'b0, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready = 1'b1;
  logic         frame_start = 1'b0;
  logic [63:0]  status_in = {32'h0BAD0002, 32'hCAFE0001};
  logic [255:0] regs_out;
  logic         pending, commit_pulse;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];   // {resp, data}

  axil_shadow_regfile #(
    .REG_COUNT(8), .STATUS_COUNT(2), .ADDR_WIDTH(8), .COMMIT_MODE(1), .RESET_VALUE(RV)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready),
    .frame_start(frame_start), .status_in(status_in), .regs_out(regs_out),
    .pending(pending), .commit_pulse(commit_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge aclk) begin
    if (!areset && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL bresp: unexpected response 0x%0h", bresp);
      end else begin
        chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
    end
    if (!areset && rvalid && rready) begin
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata: unexpected response 0x%08h", rdata);
      end else begin
        logic [33:0] e;
        e = exp_r.pop_front();
        chk("rdata", rdata, e[31:0]);
        chk("rresp", 32'(rresp), 32'(e[33:32]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // which: 0 aw, 1 w, 2 aw&w, 3 ar. Returns 1 ns after the handshake edge.
  task automatic wait_hs(input string nm, input int which);
    int  n;
    bit  ok;
    n = 0;
    do begin
      @(negedge aclk);
      case (which)
        0:       ok = awready;
        1:       ok = wready;
        2:       ok = awready && wready;
        default: ok = arready;
      endcase
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: handshake timeout got ready=0 expected ready=1", nm);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input bit fs);
    exp_b.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; frame_start = fs;
    wait_hs("write", 2);
    awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
    exp_r.push_back({er, ed});
    araddr = a; arvalid = 1'b1;
    wait_hs("read", 3);
    arvalid = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(posedge aclk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 8; i++) chk({tag, "_regs"}, regs_out[32*i +: 32], RV[32*i +: 32]);
    chk({tag, "_pending"}, 32'(pending), 0);
    chk({tag, "_bvalid"},  32'(bvalid), 0);
    chk({tag, "_rvalid"},  32'(rvalid), 0);
    chk({tag, "_readys"},  32'({awready, wready, arready}), 32'h7);
    chk({tag, "_commit"},  32'(commit_pulse), 0);
  endtask

  initial begin
    // 1: reset
    idle(3);
    areset = 1'b0;
    idle(1);
    chk_reset_state("rst");

    // 2: strobed write, staging read-back, frame commit
    axi_write(8'h04, 32'hDEADBEEF, 4'b0101, 2'b00, 1'b0);
    chk("t2_active_hold", regs_out[63:32], 32'h11223344);
    chk("t2_pending", 32'(pending), 1);
    axi_read(8'h04, 32'h11AD33EF, 2'b00);
    idle(2);
    frame_pulse();
    chk("t2_active_new", regs_out[63:32], 32'h11AD33EF);
    chk("t2_pending_clr", 32'(pending), 0);
    chk("t2_commit_pulse", 32'(commit_pulse), 1);
    idle(1);
    chk("t2_commit_low", 32'(commit_pulse), 0);
    frame_pulse();
    chk("t2_no_pulse", 32'(commit_pulse), 0);

    // 3: AW before W with bready low, then W before AW
    bready = 1'b0;
    awaddr = 8'h08; awvalid = 1'b1;
    wait_hs("aw_first", 0);
    awvalid = 1'b0;
    idle(3);
    chk("t3_have_addr_ready", 32'({awready, wready}), 32'h1);
    exp_b.push_back(2'b00);
    wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1;
    wait_hs("w_late", 1);
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_bvalid_held", 32'(bvalid), 1);
      chk("t3_bresp_stable", 32'(bresp), 0);
      idle(1);
    end
    bready = 1'b1;
    idle(1);
    chk("t3_bvalid_done", 32'(bvalid), 0);
    exp_b.push_back(2'b00);
    wdata = 32'hAABBCCDD; wstrb = 4'b1100; wvalid = 1'b1;
    wait_hs("w_first", 1);
    wvalid = 1'b0;
    chk("t3_have_data_ready", 32'({awready, wready}), 32'h2);
    idle(2);
    awaddr = 8'h0C; awvalid = 1'b1;
    wait_hs("aw_late", 0);
    awvalid = 1'b0;
    axi_read(8'h08, 32'h01020304, 2'b00);
    axi_read(8'h0C, 32'hAABB7788, 2'b00);
    idle(2);

    // 4: status registers, SLVERR, strobe-less write
    frame_pulse();
    chk("t4_reg2", regs_out[95:64], 32'h01020304);
    chk("t4_reg3", regs_out[127:96], 32'hAABB7788);
    chk("t4_pending0", 32'(pending), 0);
    axi_read(8'h20, 32'hCAFE0001, 2'b00);
    axi_read(8'h24, 32'h0BAD0002, 2'b00);
    axi_write(8'h20, 32'h12345678, 4'hF, 2'b10, 1'b0);
    idle(2);
    chk("t4_status_wr_pending", 32'(pending), 0);
    axi_read(8'h20, 32'hCAFE0001, 2'b00);
    axi_read(8'hFC, 32'h0, 2'b10);
    axi_write(8'hFC, 32'hFFFFFFFF, 4'hF, 2'b10, 1'b0);
    axi_write(8'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 1'b0);
    idle(2);
    chk("t4_strb0_pending", 32'(pending), 0);
    axi_read(8'h10, 32'h0, 2'b00);
    idle(2);

    // 5: write completion coincident with frame_start
    axi_write(8'h00, 32'h12345678, 4'hF, 2'b00, 1'b0);
    idle(2);
    axi_write(8'h00, 32'h9ABCDEF0, 4'hF, 2'b00, 1'b1);
    chk("t5_active_old", regs_out[31:0], 32'h12345678);
    chk("t5_pending_kept", 32'(pending), 1);
    chk("t5_commit_pulse", 32'(commit_pulse), 1);
    axi_read(8'h00, 32'h9ABCDEF0, 2'b00);
    idle(2);
    frame_pulse();
    chk("t5_active_next", regs_out[31:0], 32'h9ABCDEF0);
    chk("t5_pending_clr", 32'(pending), 0);
    chk("t5_commit_next", 32'(commit_pulse), 1);
    idle(2);

    // 6: reset mid-transaction
    axi_write(8'h14, 32'h0F0F0F0F, 4'hF, 2'b00, 1'b0);
    idle(2);
    awaddr = 8'h08; awvalid = 1'b1;
    wait_hs("t6_aw", 0);
    awvalid = 1'b0;
    rready = 1'b0;
    araddr = 8'h00; arvalid = 1'b1;
    wait_hs("t6_ar", 3);
    arvalid = 1'b0;
    idle(1);
    chk("t6_in_have_addr", 32'({awready, wready}), 32'h1);
    chk("t6_in_rvalid", 32'(rvalid), 1);
    chk("t6_pending_pre", 32'(pending), 1);
    #2 areset = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    idle(2);
    areset = 1'b0;
    rready = 1'b1;
    idle(3);
    chk_reset_state("post_rst");
    axi_read(8'h00, 32'h0, 2'b00);
    axi_read(8'h04, 32'h11223344, 2'b00);
    idle(4);

    chk("b_queue_empty", 32'(exp_b.size()), 0);
    chk("r_queue_empty", 32'(exp_r.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
